icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss/refill controller for the instruction cache (8 direct-mapped lines of 128 bits, word offset in address bits [3:2], index in bits [6:4]). It watches the fetch stage's hit result, stalls the pipeline on a miss, and fetches the missing line from main memory one 32-bit word per beat over a req/ack handshake. It then writes the assembled 128-bit line into the cache through the cache's `dataLine` write path and releases the stall once the cache reports a hit.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `WORD_W`, 32: memory beat width.
- `LINE_WORDS`, 4: words per line; must be a power of two and at least 2. The line is `LINE_WORDS*WORD_W` bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fetch_req`  in  1  the fetch stage is presenting `fetch_addr` this cycle.
- `fetch_addr`  in  ADDR_W  instruction address, byte-addressed.
- `cache_hit`  in  1  the cache's `hit` output for `fetch_addr`.
- `stall`  out  1  freezes the PC and IF/ID register.
- `mem_req`  out  1  beat request to main memory.
- `mem_addr`  out  ADDR_W  word-aligned beat address.
- `mem_ack`  in  1  beat accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WORD_W  beat data.
- `line_we`  out  1  one-cycle write strobe into the cache.
- `line_addr`  out  ADDR_W  line base address; offset bits are 0.
- `line_data`  out  LINE_WORDS*WORD_W  assembled line; word k occupies bits [32k+31:32k].
- `miss_cnt`  out  16  saturating count of misses.

## Operation
- States: IDLE, FETCH, FILL, RESUME.
- **IDLE**
  - `stall = fetch_req & ~cache_hit`. This is combinational, so the stall is asserted in the miss cycle itself.
  - On a miss at a clock edge:
    - latch `base = {fetch_addr[ADDR_W-1:4], 4'b0}`;
    - latch the start offset `off0`;
    - clear the beat counter;
    - increment `miss_cnt` unless it equals 0xFFFF;
    - go to FETCH.
- **FETCH**
  - `stall = 1` and `mem_req = 1`.
  - `mem_addr = base + 4*((off0 + beat) mod LINE_WORDS)`.
  - On each edge with `mem_ack = 1`:
    - store `mem_rdata` into word slot `(off0 + beat) mod LINE_WORDS`;
    - increment `beat`.
  - After the ack for beat `LINE_WORDS-1`, go to FILL.
  - `mem_req` stays high between beats, so back-to-back acks are legal.
- **FILL**
  - `stall = 1` and `line_we = 1` for exactly one cycle.
  - `line_addr = base`; `line_data` holds the full line.
  - Go to RESUME.
- **RESUME**
  - `stall = 1` for one cycle so the cache output settles on the new line. Go to IDLE.
- During FETCH, FILL and RESUME, `fetch_addr`, `fetch_req` and `cache_hit` are ignored.
- If `cache_hit` is still 0 on return to IDLE, a new miss is taken. This is legal and is not treated as an error.
- `line_addr` and `line_data` are registered and hold their values outside FILL. Consumers must qualify them with `line_we`.

## Timing
- Reset values: state IDLE; `mem_req`, `line_we` and `miss_cnt` are 0; `mem_addr`, `line_addr` and `line_data` are 0.
- `stall` is 0 when `fetch_req` is 0 during reset.
- Reset assertion mid-refill:
  - immediate return to IDLE;
  - the partial line is discarded and no `line_we` is issued;
  - `mem_req` drops asynchronously, and memory must tolerate an abandoned beat.
- Miss latency with `mem_ack` held at 1:
  - edge 0 → FETCH;
  - beats on edges 1–4;
  - FILL in cycle 5;
  - RESUME in cycle 6;
  - IDLE and hit in cycle 7.
  - `stall` is high for cycles 0–6 (7 cycles).
- Each wait cycle (`mem_ack = 0`) extends FETCH by one cycle. There is no timeout.
- `mem_addr` changes only on the edge that follows an ack.

## Configuration
- `ICACHE_CWF_EN` defined: critical word first. `off0 = fetch_addr[3:2]`, and beats wrap modulo `LINE_WORDS`.
- `ICACHE_CWF_EN` undefined: `off0 = 0`, so beats always go word 0 to word 3.
- Line contents and the FILL timing are identical in both builds; only the order of `mem_addr` values differs.

## Test plan
- **Reset/idle:** with `rst_n = 0` → all outputs 0. After release, `fetch_req = 1`, `cache_hit = 1` → `stall = 0` and `mem_req = 0` indefinitely.
- **Basic miss:**
  - Stimulus: `fetch_addr = 0x5C` (index 5, word 3), `cache_hit = 0`, memory acks every cycle returning 0xA0..0xA3.
  - Without CWF: `mem_addr` = 0x50, 0x54, 0x58, 0x5C.
  - With CWF: `mem_addr` = 0x5C, 0x50, 0x54, 0x58.
  - Both builds: `line_we` pulses once with `line_addr = 0x50` and `line_data = 0x000000A3_000000A2_000000A1_000000A0`; `stall` is high for exactly 7 cycles; `miss_cnt = 1`.
- **Wait states:** ack only every third cycle → `stall` high for 3 + 4·3 = 15 cycles; `mem_addr` is stable between acks.
- **Input churn:** `fetch_addr` toggles to 0x7C mid-FETCH → `line_addr` remains 0x50 and no extra request is issued.
- **Reset mid-refill:** pull `rst_n` low after 2 beats → `mem_req = 0` immediately, no `line_we`. The next miss to 0x7C refetches from beat 0 (0x70 without CWF, 0x7C with CWF).
- **Counter saturation:** preload via 65 535 misses (or force) → a further miss leaves `miss_cnt = 0xFFFF`.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: stalls fetch, refills one line by beats.
// Build option ICACHE_CWF_EN: fetch the missing word first, then wrap.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         cache_hit,
    output logic                         stall,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [WORD_W-1:0]            mem_rdata,
    output logic                         line_we,
    output logic [ADDR_W-1:0]            line_addr,
    output logic [LINE_WORDS*WORD_W-1:0] line_data,
    output logic [15:0]                  miss_cnt
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int BOFF_W = $clog2(WORD_W / 8);
    localparam int LOFF_W = OFF_W + BOFF_W;
    localparam int LINE_W = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {IDLE, FETCH, FILL, RESUME} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   line_addr_q;
    logic [OFF_W-1:0]    off0_q;
    logic [OFF_W-1:0]    beat_q;
    logic [LINE_W-1:0]   buf_q;
    logic [LINE_W-1:0]   line_data_q;
    logic                mem_req_q;
    logic                line_we_q;
    logic [15:0]         miss_cnt_q;

    logic                miss;
    logic [ADDR_W-1:0]   miss_base;
    logic [OFF_W-1:0]    miss_off;
    logic [OFF_W-1:0]    slot_d;
    logic [OFF_W-1:0]    next_slot_d;
    logic [LINE_W-1:0]   buf_d;
    logic                unused_addr_bits;

    assign miss      = fetch_req & ~cache_hit;
    assign miss_base = {fetch_addr[ADDR_W-1:LOFF_W], {LOFF_W{1'b0}}};
    assign unused_addr_bits = ^fetch_addr[LOFF_W-1:0];

`ifdef ICACHE_CWF_EN
    assign miss_off = fetch_addr[LOFF_W-1:BOFF_W];
`else
    assign miss_off = '0;
`endif

    // Slot arithmetic wraps naturally at OFF_W bits (modulo LINE_WORDS).
    assign slot_d      = off0_q + beat_q;
    assign next_slot_d = slot_d + OFF_W'(1);

    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] b,
        input logic [OFF_W-1:0]  s
    );
        return b | (ADDR_W'(s) << BOFF_W);
    endfunction

    always_comb begin
        buf_d = buf_q;
        buf_d[int'(slot_d)*WORD_W +: WORD_W] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            line_addr_q <= '0;
            off0_q      <= '0;
            beat_q      <= '0;
            buf_q       <= '0;
            line_data_q <= '0;
            mem_req_q   <= 1'b0;
            line_we_q   <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            line_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        base_q     <= miss_base;
                        off0_q     <= miss_off;
                        beat_q     <= '0;
                        mem_addr_q <= beat_addr(miss_base, miss_off);
                        mem_req_q  <= 1'b1;
                        if (miss_cnt_q != 16'hFFFF)
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        buf_q  <= buf_d;
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                            mem_req_q   <= 1'b0;
                            line_we_q   <= 1'b1;
                            line_addr_q <= base_q;
                            line_data_q <= buf_d;
                            state_q     <= FILL;
                        end else begin
                            mem_addr_q <= beat_addr(base_q, next_slot_d);
                        end
                    end
                end
                FILL:    state_q <= RESUME;
                RESUME:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = (state_q == IDLE) ? miss : 1'b1;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign line_we   = line_we_q;
    assign line_addr = line_addr_q;
    assign line_data = line_data_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: vector table, directed and random misses.
module tb_icache_refill_ctrl;

`ifdef ICACHE_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         cache_hit;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         line_we;
    logic [31:0]  line_addr;
    logic [127:0] line_data;
    logic [15:0]  miss_cnt;

    int checks = 0;
    int failures = 0;
    logic [15:0] cnt_model = 16'd0;
    logic [31:0] salt = 32'd0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .cache_hit  (cache_hit),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .line_we    (line_we),
        .line_addr  (line_addr),
        .line_data  (line_data),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        bit          rst;
        bit          req;
        bit          hit;
        logic [31:0] addr;
        bit          exp_stall;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory contents: a fixed pattern for the directed cases, salted hash otherwise.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (salt == 32'd0)
            return 32'hA0 + {30'd0, a[3:2]};
        return salt ^ ({a[31:2], 2'b00} * 32'h9E37_79B1);
    endfunction

    task automatic run_miss(input logic [31:0] a, input int period, input bit churn);
        logic [31:0]  base;
        int           off0;
        logic [31:0]  exp_addr[4];
        logic [127:0] exp_line;
        logic [31:0]  got_addr[$];
        logic [31:0]  got_la;
        logic [127:0] got_ld;
        logic [31:0]  prev_addr;
        bit           prev_hold;
        bit           done;
        int           stall_cnt, we_cnt, wc, unstable, cyc;
        base = a & 32'hFFFF_FFF0;
        off0 = CWF ? int'(a[3:2]) : 0;
        exp_line = '0;
        for (int k = 0; k < 4; k++) begin
            exp_addr[k] = base + 32'(4 * ((off0 + k) % 4));
            exp_line[32*k +: 32] = mdata(base + 32'(4 * k));
        end
        if (cnt_model != 16'hFFFF)
            cnt_model = cnt_model + 16'd1;
        got_la = '0; got_ld = '0; prev_addr = '0; prev_hold = 1'b0; done = 1'b0;
        stall_cnt = 0; we_cnt = 0; wc = 0; unstable = 0; cyc = 0;
        fetch_req = 1'b1;
        fetch_addr = a;
        while (!done && cyc < 400) begin
            if (churn && cyc == 2)
                fetch_addr = 32'h7C;
            cache_hit = (we_cnt > 0);
            if (mem_req) begin
                mem_ack = (wc == period - 1);
                wc = mem_ack ? 0 : wc + 1;
            end else begin
                mem_ack = 1'b0;
            end
            mem_rdata = mdata(mem_addr);
            if (prev_hold && mem_req && mem_addr !== prev_addr)
                unstable++;
            prev_hold = mem_req && !mem_ack;
            prev_addr = mem_addr;
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                if (mem_ack)
                    got_addr.push_back(mem_addr);
                if (line_we) begin
                    we_cnt++;
                    got_la = line_addr;
                    got_ld = line_data;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        if (!done)
            chk("refill_timeout", 128'(0), 128'(1));
        chk("stall_cycles", 128'(stall_cnt), 128'(3 + 4 * period));
        chk("beat_count", 128'(got_addr.size()), 128'(4));
        for (int k = 0; k < got_addr.size() && k < 4; k++)
            chk($sformatf("mem_addr_beat%0d", k), 128'(got_addr[k]), 128'(exp_addr[k]));
        chk("line_we_pulses", 128'(we_cnt), 128'(1));
        chk("line_addr", 128'(got_la), 128'(base));
        chk("line_data", got_ld, exp_line);
        chk("miss_cnt", 128'(miss_cnt), 128'(cnt_model));
        chk("mem_addr_stable", 128'(unstable), 128'(0));
        chk("mem_req_after", 128'(mem_req), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int we_seen;
        tv[0] = '{1'b0, 1'b0, 1'b0, 32'h5C, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 32'h5C, 1'b1};
        tv[2] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b0};
        tv[4] = '{1'b1, 1'b1, 1'b1, 32'h5C, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0};
        tv[6] = '{1'b1, 1'b0, 1'b0, 32'h7C, 1'b0};
        tv[7] = '{1'b1, 1'b1, 1'b1, 32'h7C, 1'b0};

        rst_n = 1'b0;
        fetch_req = 1'b0;
        fetch_addr = '0;
        cache_hit = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            rst_n = tv[i].rst;
            fetch_req = tv[i].req;
            cache_hit = tv[i].hit;
            fetch_addr = tv[i].addr;
            #1;
            chk($sformatf("vec%0d_stall", i), 128'(stall), 128'(tv[i].exp_stall));
            chk($sformatf("vec%0d_regs", i),
                128'({mem_req, line_we, miss_cnt, mem_addr, line_addr}), 128'(0));
            chk($sformatf("vec%0d_line_data", i), line_data, 128'(0));
            @(posedge clk);
            #1;
        end

        salt = 32'd0;
        run_miss(32'h5C, 1, 1'b0);
        run_miss(32'h5C, 3, 1'b0);
        run_miss(32'h5C, 2, 1'b1);

        // Abandon a refill after two beats, then refetch a new line from its first beat.
        fetch_req = 1'b1;
        fetch_addr = 32'h5C;
        cache_hit = 1'b0;
        acks = 0;
        for (int c = 0; c < 20 && acks < 2; c++) begin
            mem_ack = mem_req;
            mem_rdata = mdata(mem_addr);
            #1;
            if (mem_ack)
                acks++;
            @(posedge clk);
            #1;
        end
        chk("pre_reset_beats", 128'(acks), 128'(2));
        chk("pre_reset_mem_req", 128'(mem_req), 128'(1));
        mem_ack = 1'b0;
        fetch_req = 1'b0;
        cache_hit = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_mem_req", 128'(mem_req), 128'(0));
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_miss_cnt", 128'(miss_cnt), 128'(0));
        we_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            we_seen += int'(line_we);
        end
        chk("reset_no_line_we", 128'(we_seen), 128'(0));
        fetch_req = 1'b1;
        rst_n = 1'b1;
        cnt_model = 16'd0;
        @(posedge clk);
        #1;
        run_miss(32'h7C, 1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            salt = $urandom | 32'd1;
            run_miss($urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        cnt_model = 16'hFFFE;
        run_miss(32'h1234, 1, 1'b0);
        run_miss(32'h0040, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
